// File: rtl/apu_mixer_dac_if.sv
// Channel-level bundle between the APU voices and the mixer/DAC block.
// The master side drives channel levels and controls; the slave side returns the mix and bitstream.
interface apu_mixer_dac_if;
   logic       enable;
   logic [1:0] master_shift;
   logic [3:0] pulse1_in;
   logic [3:0] pulse2_in;
   logic [3:0] triangle_in;
   logic [3:0] noise_in;
   logic [7:0] mix_out;
   logic       mix_valid;
   logic       dac_out;

   modport master (
      output enable,
      output master_shift,
      output pulse1_in,
      output pulse2_in,
      output triangle_in,
      output noise_in,
      input  mix_out,
      input  mix_valid,
      input  dac_out
   );

   modport slave (
      input  enable,
      input  master_shift,
      input  pulse1_in,
      input  pulse2_in,
      input  triangle_in,
      input  noise_in,
      output mix_out,
      output mix_valid,
      output dac_out
   );
endinterface

// File: rtl/apu_mixer_dac.sv
// Samples the four APU channel levels every SAMPLE_DIV clocks, forms a weighted
// attenuated 8-bit mix and drives a first-order delta-sigma bitstream from it.
module apu_mixer_dac #(
   parameter int SAMPLE_DIV = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   apu_mixer_dac_if.slave  bus
);

   localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_DIV - 1);

   logic [CNT_W-1:0] sample_cnt;
   logic             strobe;
   logic             strobe_d;

   logic [3:0] pulse1_q;
   logic [3:0] pulse2_q;
   logic [3:0] triangle_q;
   logic [3:0] noise_q;

   logic [8:0] raw_mix;
   logic [7:0] mix_shifted;
   logic [7:0] mix_q;
   logic       mix_valid_q;

   logic [7:0] acc_q;
   logic [8:0] acc_next;
   logic       dac_q;

   assign strobe = (sample_cnt == CNT_MAX);

   // Free-running sample divider; keeps counting while muted so the sample grid never shifts.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sample_cnt <= '0;
      end else if (strobe) begin
         sample_cnt <= '0;
      end else begin
         sample_cnt <= sample_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pulse1_q   <= '0;
         pulse2_q   <= '0;
         triangle_q <= '0;
         noise_q    <= '0;
         strobe_d   <= 1'b0;
      end else begin
         strobe_d <= strobe;
         if (strobe) begin
            pulse1_q   <= bus.pulse1_in;
            pulse2_q   <= bus.pulse2_in;
            triangle_q <= bus.triangle_in;
            noise_q    <= bus.noise_in;
         end
      end
   end

   // Worst case 2*15 + 2*15 + 3*15 + 2*15 = 135, so the shifted result always fits in 8 bits.
   always_comb begin
      raw_mix     = 9'(pulse1_q)   * 9'd2
                  + 9'(pulse2_q)   * 9'd2
                  + 9'(triangle_q) * 9'd3
                  + 9'(noise_q)    * 9'd2;
      mix_shifted = 8'(raw_mix >> bus.master_shift);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mix_q       <= '0;
         mix_valid_q <= 1'b0;
      end else begin
         mix_valid_q <= strobe_d;
         if (strobe_d) begin
            mix_q <= bus.enable ? mix_shifted : 8'd0;
         end
      end
   end

   // Only the low byte of the accumulator feeds back; the carry out is the output bit.
   assign acc_next = {1'b0, acc_q} + {1'b0, mix_q};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
         dac_q <= 1'b0;
      end else if (!bus.enable) begin
         acc_q <= '0;
         dac_q <= 1'b0;
      end else begin
         acc_q <= acc_next[7:0];
         dac_q <= acc_next[8];
      end
   end

   assign bus.mix_out   = mix_q;
   assign bus.mix_valid = mix_valid_q;
   assign bus.dac_out   = dac_q;

endmodule

// File: tb/tb_apu_mixer_dac.sv
// Directed bench for apu_mixer_dac: a vector table for the mix/bitstream function plus
// hand-written sequences for reset, shift timing, muting, glitches and SAMPLE_DIV=1.
module tb_apu_mixer_dac;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   apu_mixer_dac_if bus32();
   apu_mixer_dac_if bus1();

   apu_mixer_dac #(.SAMPLE_DIV(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
   apu_mixer_dac #(.SAMPLE_DIV(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] p1;
      logic [3:0] p2;
      logic [3:0] tri_lvl;
      logic [3:0] noise;
      logic [1:0] shift;
      logic       en;
      int         exp_mix;
      int         exp_highs;
   } vec_t;

   vec_t vecs[8];
   int   vec_count = 0;
   int   miscompares = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      vec_count++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      bus32.pulse1_in    = v.p1;
      bus32.pulse2_in    = v.p2;
      bus32.triangle_in  = v.tri_lvl;
      bus32.noise_in     = v.noise;
      bus32.master_shift = v.shift;
      bus32.enable       = v.en;
   endtask

   // Advances to the negedge following the next mix_valid pulse, with a cycle budget.
   task automatic waitValid(input string name);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus32.mix_valid) return;
      end
      vec_count++;
      miscompares++;
      $display("[TB] FAIL %s: mix_valid timeout, got none, expected pulse within 100 clks", name);
   endtask

   task automatic countHighs(input int clocks, output int highs);
      highs = 0;
      for (int i = 0; i < clocks; i++) begin
         @(negedge clk);
         if (bus32.dac_out) highs++;
      end
   endtask

   initial begin
      int   first32;
      int   first1;
      int   highs;
      int   seq1[8];
      vec_t v;

      vecs[0] = '{4'd15, 4'd15, 4'd15, 4'd15, 2'd0, 1'b1, 135, 135};
      vecs[1] = '{4'd1,  4'd0,  4'd0,  4'd0,  2'd0, 1'b1, 2,   2};
      vecs[2] = '{4'd0,  4'd0,  4'd15, 4'd0,  2'd0, 1'b1, 45,  45};
      vecs[3] = '{4'd15, 4'd15, 4'd15, 4'd15, 2'd2, 1'b1, 33,  33};
      vecs[4] = '{4'd0,  4'd5,  4'd3,  4'd7,  2'd1, 1'b1, 16,  16};
      vecs[5] = '{4'd3,  4'd4,  4'd5,  4'd6,  2'd0, 1'b1, 41,  41};
      vecs[6] = '{4'd15, 4'd15, 4'd15, 4'd15, 2'd3, 1'b0, 0,   0};
      vecs[7] = '{4'd9,  4'd0,  4'd0,  4'd15, 2'd3, 1'b1, 6,   6};
      seq1 = '{0, 15, 7, 3, 9, 1, 12, 0};

      applyStimulus(vecs[0]);
      bus1.pulse1_in    = 4'd15;
      bus1.pulse2_in    = 4'd15;
      bus1.triangle_in  = 4'd15;
      bus1.noise_in     = 4'd15;
      bus1.master_shift = 2'd0;
      bus1.enable       = 1'b1;

      // Reset held for three clocks with every input at full scale
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset mix_out",       int'(bus32.mix_out),   0);
      checkOutput("reset mix_valid",     int'(bus32.mix_valid), 0);
      checkOutput("reset dac_out",       int'(bus32.dac_out),   0);
      checkOutput("reset div1 mix_out",  int'(bus1.mix_out),    0);
      checkOutput("reset div1 mix_valid",int'(bus1.mix_valid),  0);
      checkOutput("reset div1 dac_out",  int'(bus1.dac_out),    0);

      rst_n   = 1'b1;
      first32 = 0;
      first1  = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (first32 == 0 && bus32.mix_valid) first32 = k;
         if (first1 == 0 && bus1.mix_valid) first1 = k;
      end
      checkOutput("first mix_valid clk (div32)", first32, 33);
      checkOutput("first mix_valid clk (div1)",  first1,  2);

      for (int i = 0; i < 8; i++) begin
         waitValid("vector sync");
         applyStimulus(vecs[i]);
         waitValid("vector result");
         checkOutput($sformatf("vec%0d mix_out", i), int'(bus32.mix_out), vecs[i].exp_mix);
         countHighs(256, highs);
         checkOutput($sformatf("vec%0d dac highs/256", i), highs, vecs[i].exp_highs);
      end

      // Shift changed after the input capture edge but before the mix edge must apply immediately
      waitValid("shift sync");
      v = vecs[0];
      applyStimulus(v);
      waitValid("shift base");
      checkOutput("shift base mix_out", int'(bus32.mix_out), 135);
      @(negedge clk);
      checkOutput("mix_valid single pulse", int'(bus32.mix_valid), 0);
      repeat (30) @(negedge clk);
      checkOutput("mix_out held between strobes", int'(bus32.mix_out), 135);
      bus32.master_shift = 2'd2;
      waitValid("shift late");
      checkOutput("late shift mix_out", int'(bus32.mix_out), 33);

      // Mute mid-stream and re-enable
      bus32.master_shift = 2'd0;
      waitValid("mute base");
      checkOutput("mute base mix_out", int'(bus32.mix_out), 135);
      repeat (5) @(negedge clk);
      bus32.enable = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("dac_out cleared on mute", int'(bus32.dac_out), 0);
      countHighs(15, highs);
      checkOutput("dac highs while muted", highs, 0);
      checkOutput("mix_out before mute strobe", int'(bus32.mix_out), 135);
      waitValid("mute strobe");
      checkOutput("muted mix_out", int'(bus32.mix_out), 0);
      bus32.enable = 1'b1;
      waitValid("unmute strobe");
      checkOutput("unmuted mix_out", int'(bus32.mix_out), 135);

      // Input pulse that begins and ends between two strobes is invisible
      v = '{4'd2, 4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 4, 4};
      applyStimulus(v);
      waitValid("glitch base");
      checkOutput("glitch base mix_out", int'(bus32.mix_out), 4);
      repeat (5) @(negedge clk);
      bus32.pulse1_in = 4'd15;
      repeat (10) @(negedge clk);
      bus32.pulse1_in = 4'd2;
      waitValid("glitch result");
      checkOutput("glitch mix_out unchanged", int'(bus32.mix_out), 4);

      // SAMPLE_DIV=1: mix follows pulse1 with two clocks of latency
      bus1.pulse2_in   = 4'd0;
      bus1.triangle_in = 4'd0;
      bus1.noise_in    = 4'd0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i >= 2) checkOutput($sformatf("div1 track step %0d", i - 2),
                                 int'(bus1.mix_out), 2 * seq1[i - 2]);
         if (i < 8) bus1.pulse1_in = 4'(seq1[i]);
      end
      checkOutput("div1 mix_valid stuck high", int'(bus1.mix_valid), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
